// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 8N1 UART transmitter: frame width, FSM states
// and the tick-counter width helper.
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // One bit time is 2*divisor cycles; a divisor of 1 still needs a 1-bit counter.
    function automatic int tick_w(input int divisor);
        return (divisor < 2) ? 1 : $clog2(2 * divisor);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: pulses bit_end on the last cycle of every 2*divisor-cycle
// bit while run is high; the counter is held at zero otherwise.
module uart_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int divisor = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int TW = tick_w(divisor);
    localparam logic [TW-1:0] LAST = TW'(2 * divisor - 1);

    logic [TW-1:0] tick;

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            tick <= '0;
        end else if (tick == LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    assign bit_end = run && (tick == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a valid/ready handshake and sends
// start bit, 8 data bits LSB first, and a stop bit on txo.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int divisor = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txo,
    output logic       busy
);

    uart_state_e state;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        run;
    logic        bit_end;

    assign run = (state != IDLE);

    uart_bit_timer #(
        .divisor (divisor)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bit_end (bit_end)
    );

    // The shift register is datapath and is only loaded on accept, so it has no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            txo     <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        shift <= data;
                        state <= START;
                        txo   <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        txo   <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            state   <= STOP;
                            txo     <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txo     <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    txo   <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (divisor 32 and 1) with a serial-decoding
// monitor per instance that checks each frame against a queue of expected bytes.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       valid [2];
    logic [7:0] data  [2];
    logic       ready [2];
    logic       txo   [2];
    logic       busy  [2];

    uart_tx #(.divisor(32)) dut32 (
        .clk(clk), .rst(rst[0]), .data(data[0]), .valid(valid[0]),
        .ready(ready[0]), .txo(txo[0]), .busy(busy[0])
    );

    uart_tx #(.divisor(1)) dut1 (
        .clk(clk), .rst(rst[1]), .data(data[1]), .valid(valid[1]),
        .ready(ready[1]), .txo(txo[1]), .busy(busy[1])
    );

    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    longint starts0[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Decodes frames on txo by sampling each bit at its midpoint.
    task automatic mon(input int idx, input int d);
        logic       prev = 1'b1;
        logic       aborted;
        logic       sb;
        logic       pb;
        logic [7:0] rx;
        forever begin
            @(negedge clk);
            if (rst[idx] === 1'b1 && prev === 1'b1 && txo[idx] === 1'b0) begin
                if (idx == 0) starts0.push_back(cyc);
                aborted = 1'b0;
                repeat (d) begin
                    @(negedge clk);
                    if (rst[idx] !== 1'b1) aborted = 1'b1;
                end
                sb = txo[idx];
                for (int k = 0; k < 8; k++) begin
                    repeat (2 * d) begin
                        @(negedge clk);
                        if (rst[idx] !== 1'b1) aborted = 1'b1;
                    end
                    rx[k] = txo[idx];
                end
                repeat (2 * d) begin
                    @(negedge clk);
                    if (rst[idx] !== 1'b1) aborted = 1'b1;
                end
                pb = txo[idx];
                prev = txo[idx];
                if (!aborted) begin
                    if (idx == 0) begin
                        chk("frame_expected_d32", int'(q0.size() > 0), 1);
                        if (q0.size() > 0) chk("data_byte_d32", int'(rx), int'(q0.pop_front()));
                    end else begin
                        chk("frame_expected_d1", int'(q1.size() > 0), 1);
                        if (q1.size() > 0) chk("data_byte_d1", int'(rx), int'(q1.pop_front()));
                    end
                    chk("start_bit", int'(sb), 0);
                    chk("stop_bit", int'(pb), 1);
                end
            end else begin
                prev = txo[idx];
            end
        end
    endtask

    initial mon(0, 32);
    initial mon(1, 1);

    // Presents one byte when the transmitter is ready; returns on the negedge after accept.
    task automatic send(input int idx, input logic [7:0] b, input bit push);
        int n = 0;
        @(negedge clk);
        while (ready[idx] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("send_ready_timeout", 0, 1);
        if (push) begin
            if (idx == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
        valid[idx] = 1'b1;
        data[idx]  = b;
        @(negedge clk);
        valid[idx] = 1'b0;
    endtask

    task automatic abort_test(input int idx, input int d);
        send(idx, 8'h5A, 1'b0);
        repeat (11 * d) @(negedge clk);
        rst[idx] = 1'b0;
        @(negedge clk);
        chk("abort_txo", int'(txo[idx]), 1);
        chk("abort_ready", int'(ready[idx]), 1);
        chk("abort_busy", int'(busy[idx]), 0);
        @(negedge clk);
        rst[idx] = 1'b1;
        repeat (25 * d + 5) @(negedge clk);
        send(idx, 8'h81, 1'b1);
    endtask

    initial begin
        int n;
        longint c0;
        int base;

        // Reset with valid asserted: nothing may be accepted.
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; valid[i] = 1'b1; data[i] = 8'h55;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_txo", int'(txo[i]), 1);
            chk("reset_ready", int'(ready[i]), 1);
            chk("reset_busy", int'(busy[i]), 0);
            rst[i] = 1'b1; valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_reset_txo", int'(txo[i]), 1);
            chk("post_reset_busy", int'(busy[i]), 0);
        end

        // Single 0xA5 and ready-return latency.
        send(0, 8'hA5, 1'b1);
        chk("first_txo_low", int'(txo[0]), 0);
        chk("busy_after_accept", int'(busy[0]), 1);
        chk("ready_after_accept", int'(ready[0]), 0);
        c0 = cyc;
        n = 0;
        while (ready[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_return_latency", int'(cyc - c0), 640);

        // Loopback of every byte value through the divisor-1 instance.
        for (int v = 0; v < 256; v++) send(1, 8'(v), 1'b1);

        // Back-to-back frames with valid held high.
        base = starts0.size();
        @(negedge clk);
        q0.push_back(8'h00);
        q0.push_back(8'hFF);
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        @(negedge clk);
        data[0] = 8'hFF;
        n = 0;
        while (ready[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        valid[0] = 1'b0;
        n = 0;
        while (starts0.size() < base + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_frames_seen", int'(starts0.size() >= base + 2), 1);
        if (starts0.size() >= base + 2)
            chk("b2b_frame_period", int'(starts0[base + 1] - starts0[base]), 641);

        // valid while busy is ignored.
        send(0, 8'h11, 1'b1);
        repeat (100) @(negedge clk);
        chk("ready_low_while_busy", int'(ready[0]), 0);
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        @(negedge clk);
        valid[0] = 1'b0;
        send(0, 8'h96, 1'b1);

        // Reset during DATA bit 4, then a clean frame.
        abort_test(0, 32);
        abort_test(1, 1);

        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drain", q0.size() + q1.size(), 0);
        repeat (4) @(negedge clk);
        chk("idle_txo_d32", int'(txo[0]), 1);
        chk("idle_txo_d1", int'(txo[1]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
